// File: rtl/fsl_echo_responder.sv
// rtl/fsl_echo_responder.sv - FSL loopback peer: buffers a packet, echoes it back, then appends a status trailer
// Optional build macro FSL_ECHO_PKTCNT_EN adds the pkt_count output and its counter.
module fsl_echo_responder #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic        gclk,
   input  logic        reset,
   input  logic        fsl_in_write,
   input  logic [31:0] fsl_in_data,
   input  logic        fsl_in_control,
   output logic        fsl_in_full,
   output logic        fsl_out_exists,
   output logic [31:0] fsl_out_data,
   output logic        fsl_out_control,
   input  logic        fsl_out_read
`ifdef FSL_ECHO_PKTCNT_EN
   ,
   output logic [7:0]  pkt_count
`endif
);

   localparam logic [1:0] ST_RX       = 2'd0;
   localparam logic [1:0] ST_TX_DATA  = 2'd1;
   localparam logic [1:0] ST_TX_TRAIL = 2'd2;

   // wr_ptr needs one extra bit so it can reach DEPTH ("buffer full")
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE_W   = (AW+1)'(1);

   logic [1:0]    state_q, state_d;
   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [15:0]   sum_q, sum_d;
   logic          ovf_q, ovf_d;
   logic          mem_we;
   logic          trailer_pop;
   logic [31:0]   mem_q [DEPTH];

   // Output stream is a pure function of registered state, so data stays stable while unpopped
   always_comb begin
      fsl_in_full     = 1'b0;
      fsl_out_exists  = 1'b0;
      fsl_out_data    = 32'd0;
      fsl_out_control = 1'b0;
      case (state_q)
         ST_TX_DATA: begin
            fsl_in_full    = 1'b1;
            fsl_out_exists = 1'b1;
            fsl_out_data   = mem_q[rd_ptr_q];
         end
         ST_TX_TRAIL: begin
            fsl_in_full     = 1'b1;
            fsl_out_exists  = 1'b1;
            fsl_out_control = 1'b1;
            fsl_out_data    = {ovf_q, 7'd0, cnt_q, sum_q};
         end
         default: ;
      endcase
   end

   // Next-state logic: collect packet in RX, replay it in TX_DATA, emit trailer in TX_TRAIL
   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      cnt_d       = cnt_q;
      sum_d       = sum_q;
      ovf_d       = ovf_q;
      mem_we      = 1'b0;
      trailer_pop = 1'b0;
      case (state_q)
         ST_RX: begin
            if (fsl_in_write) begin
               // Words past the buffer end are still counted and summed, only their storage is skipped
               if (wr_ptr_q < DEPTH_W) begin
                  mem_we   = 1'b1;
                  wr_ptr_d = wr_ptr_q + ONE_W;
               end else begin
                  ovf_d = 1'b1;
               end
               cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
               sum_d = sum_q + fsl_in_data[15:0];
               if (fsl_in_control) begin
                  state_d  = ST_TX_DATA;
                  rd_ptr_d = '0;
               end
            end
         end
         ST_TX_DATA: begin
            if (fsl_out_read) begin
               rd_ptr_d = rd_ptr_q + 1'b1;
               if ({1'b0, rd_ptr_q} == (wr_ptr_q - ONE_W)) begin
                  state_d = ST_TX_TRAIL;
               end
            end
         end
         ST_TX_TRAIL: begin
            if (fsl_out_read) begin
               trailer_pop = 1'b1;
               state_d     = ST_RX;
               wr_ptr_d    = '0;
               rd_ptr_d    = '0;
               cnt_d       = 8'd0;
               sum_d       = 16'd0;
               ovf_d       = 1'b0;
            end
         end
         default: state_d = ST_RX;
      endcase
   end

   // Control registers with synchronous reset that overrides everything
   always_ff @(posedge gclk) begin
      if (reset) begin
         state_q  <= ST_RX;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= 8'd0;
         sum_q    <= 16'd0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         sum_q    <= sum_d;
         ovf_q    <= ovf_d;
      end
   end

   // Packet buffer storage; contents need no reset since pointers gate every read
   always_ff @(posedge gclk) begin
      if (mem_we && !reset) begin
         mem_q[wr_ptr_q[AW-1:0]] <= fsl_in_data;
      end
   end

`ifdef FSL_ECHO_PKTCNT_EN
   logic [7:0] pkt_count_q, pkt_count_d;

   // Completed-packet counter, bumped when the trailer is consumed, wraps naturally
   always_comb begin
      pkt_count_d = pkt_count_q;
      if (trailer_pop) begin
         pkt_count_d = pkt_count_q + 8'd1;
      end
   end

   // Counter register
   always_ff @(posedge gclk) begin
      if (reset) begin
         pkt_count_q <= 8'd0;
      end else begin
         pkt_count_q <= pkt_count_d;
      end
   end

   assign pkt_count = pkt_count_q;
`else
   logic unused_trailer_pop;
   assign unused_trailer_pop = trailer_pop;
`endif

endmodule
